// File: rtl/ace_line_mem.sv
// ace_line_mem: ACE slave memory, one line per beat, one transaction in flight, no snoops.
// Define ACE_LINE_MEM_DECERR_EN to answer DECERR for addresses beyond DEPTH lines instead of wrapping.
module ace_line_mem #(
    parameter int unsigned XDATA_WIDTH  = 256,
    parameter int unsigned AXADDR_WIDTH = 32,
    parameter int unsigned DEPTH        = 1024,
    parameter int unsigned ID_WIDTH     = 4,
    parameter int unsigned USER_WIDTH   = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ID_WIDTH-1:0]        i_awid,
    input  logic [AXADDR_WIDTH-1:0]    i_awaddr,
    input  logic [7:0]                 i_awlen,
    input  logic [2:0]                 i_awsize,
    input  logic [1:0]                 i_awburst,
    input  logic                       i_awlock,
    input  logic [3:0]                 i_awcache,
    input  logic [2:0]                 i_awprot,
    input  logic [3:0]                 i_awqos,
    input  logic [3:0]                 i_awregion,
    input  logic [USER_WIDTH-1:0]      i_awuser,
    input  logic [2:0]                 i_awsnoop,
    input  logic [1:0]                 i_awdomain,
    input  logic [1:0]                 i_awbar,
    input  logic                       i_awvalid,
    output logic                       o_awready,
    input  logic [XDATA_WIDTH-1:0]     i_wdata,
    input  logic [XDATA_WIDTH/8-1:0]   i_wstrb,
    input  logic                       i_wlast,
    input  logic [USER_WIDTH-1:0]      i_wuser,
    input  logic                       i_wvalid,
    output logic                       o_wready,
    output logic [ID_WIDTH-1:0]        o_bid,
    output logic [1:0]                 o_bresp,
    output logic [USER_WIDTH-1:0]      o_buser,
    output logic                       o_bvalid,
    input  logic                       i_bready,
    input  logic [ID_WIDTH-1:0]        i_arid,
    input  logic [AXADDR_WIDTH-1:0]    i_araddr,
    input  logic [7:0]                 i_arlen,
    input  logic [2:0]                 i_arsize,
    input  logic [1:0]                 i_arburst,
    input  logic                       i_arlock,
    input  logic [3:0]                 i_arcache,
    input  logic [2:0]                 i_arprot,
    input  logic [3:0]                 i_arqos,
    input  logic [3:0]                 i_arregion,
    input  logic [USER_WIDTH-1:0]      i_aruser,
    input  logic [3:0]                 i_arsnoop,
    input  logic [1:0]                 i_ardomain,
    input  logic [1:0]                 i_arbar,
    input  logic                       i_arvalid,
    output logic                       o_arready,
    output logic [ID_WIDTH-1:0]        o_rid,
    output logic [XDATA_WIDTH-1:0]     o_rdata,
    output logic [3:0]                 o_rresp,
    output logic                       o_rlast,
    output logic [USER_WIDTH-1:0]      o_ruser,
    output logic                       o_rvalid,
    input  logic                       i_rready,
    output logic                       o_acvalid,
    input  logic                       i_acready,
    output logic [AXADDR_WIDTH-1:0]    o_acaddr,
    output logic [3:0]                 o_acsnoop,
    output logic [2:0]                 o_acprot,
    input  logic                       i_crvalid,
    output logic                       o_crready,
    input  logic [4:0]                 i_crresp,
    input  logic                       i_cdvalid,
    output logic                       o_cdready,
    input  logic [XDATA_WIDTH-1:0]     i_cddata,
    input  logic                       i_cdlast,
    input  logic                       i_rack,
    input  logic                       i_wack
);

    localparam int unsigned IDXW   = $clog2(DEPTH);
    localparam int unsigned NBYTES = XDATA_WIDTH / 8;

    typedef enum logic [2:0] {
        StIdle, StRdResp, StWaitRack, StWrData, StWrResp, StWaitWack
    } state_e;

    state_e                 r_state;
    state_e                 w_state_nxt;
    logic                   r_rd_last;
    logic [ID_WIDTH-1:0]    r_id;
    logic [1:0]             r_resp;
    logic [IDXW-1:0]        r_idx;
    logic                   r_wr_en;
    logic [XDATA_WIDTH-1:0] r_rdata;
    logic [XDATA_WIDTH-1:0] r_mem [DEPTH];

    logic                   w_ar_hs;
    logic                   w_aw_hs;
    logic                   w_w_hs;
    logic                   w_ar_decerr;
    logic                   w_aw_decerr;
    logic [IDXW-1:0]        w_ar_idx;
    logic [IDXW-1:0]        w_aw_idx;
    logic                   w_both;
    logic                   w_unused;

    assign w_ar_idx = i_araddr[IDXW+4:5];
    assign w_aw_idx = i_awaddr[IDXW+4:5];

`ifdef ACE_LINE_MEM_DECERR_EN
    assign w_ar_decerr = |i_araddr[AXADDR_WIDTH-1:IDXW+5];
    assign w_aw_decerr = |i_awaddr[AXADDR_WIDTH-1:IDXW+5];
`else
    assign w_ar_decerr = 1'b0;
    assign w_aw_decerr = 1'b0;
`endif

    assign w_both  = i_arvalid && i_awvalid;
    assign w_ar_hs = i_arvalid && o_arready;
    assign w_aw_hs = i_awvalid && o_awready;
    assign w_w_hs  = i_wvalid && o_wready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Completion acks only count once the FSM is parked in a WAIT_* state.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_ar_hs) begin
                    w_state_nxt = StRdResp;
                end else if (w_aw_hs) begin
                    w_state_nxt = StWrData;
                end
            end
            StRdResp:   if (i_rready)           w_state_nxt = StWaitRack;
            StWaitRack: if (i_rack)             w_state_nxt = StIdle;
            StWrData:   if (w_w_hs && i_wlast)  w_state_nxt = StWrResp;
            StWrResp:   if (i_bready)           w_state_nxt = StWaitWack;
            StWaitWack: if (i_wack)             w_state_nxt = StIdle;
            default:                            w_state_nxt = StIdle;
        endcase
    end

    // Readies are gated by rst so they drop the instant reset asserts.
    always_comb begin
        o_arready = 1'b0;
        o_awready = 1'b0;
        o_rvalid  = 1'b0;
        o_wready  = 1'b0;
        o_bvalid  = 1'b0;
        unique case (r_state)
            StIdle: begin
                o_arready = rst && !(w_both && r_rd_last);
                o_awready = rst && !(w_both && !r_rd_last);
            end
            StRdResp:   o_rvalid = 1'b1;
            StWrData:   o_wready = 1'b1;
            StWrResp:   o_bvalid = 1'b1;
            StWaitRack, StWaitWack: ;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_last <= 1'b0;
            r_id      <= '0;
            r_resp    <= 2'b00;
            r_idx     <= '0;
            r_wr_en   <= 1'b0;
            r_rdata   <= '0;
        end else if (w_ar_hs) begin
            r_rd_last <= ~r_rd_last;
            r_id      <= i_arid;
            r_idx     <= w_ar_idx;
            r_wr_en   <= 1'b0;
            r_resp    <= w_ar_decerr ? 2'b11 : ((i_arlen != 8'd0) ? 2'b10 : 2'b00);
            r_rdata   <= w_ar_decerr ? '0 : r_mem[w_ar_idx];
        end else if (w_aw_hs) begin
            r_rd_last <= ~r_rd_last;
            r_id      <= i_awid;
            r_idx     <= w_aw_idx;
            r_wr_en   <= !w_aw_decerr && (i_awlen == 8'd0);
            r_resp    <= w_aw_decerr ? 2'b11 : ((i_awlen != 8'd0) ? 2'b10 : 2'b00);
        end
    end

    always_ff @(posedge clk) begin
        if (w_w_hs && r_wr_en) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (i_wstrb[b]) begin
                    r_mem[r_idx][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    assign o_rid     = r_id;
    assign o_rdata   = r_rdata;
    assign o_rresp   = {2'b00, r_resp};
    assign o_rlast   = o_rvalid;
    assign o_ruser   = '0;
    assign o_bid     = r_id;
    assign o_bresp   = r_resp;
    assign o_buser   = '0;
    assign o_acvalid = 1'b0;
    assign o_acaddr  = '0;
    assign o_acsnoop = 4'd0;
    assign o_acprot  = 3'd0;
    assign o_crready = 1'b1;
    assign o_cdready = 1'b1;

    assign w_unused = ^{i_awaddr, i_awsize, i_awburst, i_awlock, i_awcache, i_awprot, i_awqos,
                        i_awregion, i_awuser, i_awsnoop, i_awdomain, i_awbar, i_wuser,
                        i_araddr, i_arsize, i_arburst, i_arlock, i_arcache, i_arprot, i_arqos,
                        i_arregion, i_aruser, i_arsnoop, i_ardomain, i_arbar, i_acready,
                        i_crvalid, i_crresp, i_cdvalid, i_cddata, i_cdlast};

endmodule

// File: doc/ace_line_mem.md
# ace_line_mem

Single-port, line-granular ACE slave memory that sits directly downstream of the LSU's ACE master port and serves its AR/R and AW/W/B traffic from an internal line array. It handles one transaction at a time, honours the ACE RACK/WACK completion handshake, and never issues snoops. It is the LSU's memory endpoint for block-level benches and small SoC builds that have no interconnect.

## Interface
- XDATA_WIDTH, 256: line and data-bus width in bits, one line per beat.
- AXADDR_WIDTH, 32: address width.
- DEPTH, 1024: number of lines stored; must be a power of two.
- clk  input  1  sole clock; all logic is on the rising edge.
- rst  input  1  asynchronous, active-low reset; also drives the `_n` reset of the memory model.
- mem_ace_if  ace_if (slave side)  —  full ACE bundle from the LSU.
  - Drives: awready, wready, bid, bresp, buser, bvalid, arready, rid, rdata, rresp, rlast, ruser, rvalid, acvalid, acaddr, acsnoop, acprot, crready, cdready.
  - Samples: all remaining signals.

## Operation
- Line index is addr[$clog2(DEPTH)+4:5]; address bits [4:0] are ignored.
- State machine states: IDLE, RD_RESP, WAIT_RACK, WR_DATA, WR_RESP, WAIT_WACK.
- IDLE
  - arready and awready are 1.
  - If only one of arvalid/awvalid is high, that request is accepted.
  - If both are high, a priority bit `rd_last` decides: read wins when rd_last=0, write wins when rd_last=1. Only the winner's ready is asserted in that cycle. rd_last toggles on every acceptance.
- Read
  - AR handshake latches arid, arlen and the line index; the array is read; the FSM goes to RD_RESP.
  - RD_RESP drives rvalid=1, rlast=1, rid=arid, rdata=line, rresp[1:0]=OKAY, rresp[3:2]=0.
  - arlen≠0 gives rresp[1:0]=SLVERR (2'b10) with a single beat.
  - On the R handshake the FSM goes to WAIT_RACK; on rack=1 it goes to IDLE.
- Write
  - AW handshake latches awid, awlen and the index; the FSM goes to WR_DATA with wready=1.
  - Each W handshake with awlen=0 writes the bytes selected by wstrb.
  - With awlen≠0, beats are consumed but nothing is written, and the response is SLVERR.
  - The W handshake with wlast=1 moves the FSM to WR_RESP: bvalid=1, bid=awid.
  - On the B handshake the FSM goes to WAIT_WACK; on wack=1 it goes to IDLE.
- Snoop side: acvalid=0 always; crready=1 and cdready=1 always, so any stray CR/CD beats are dropped.
- buser and ruser are 0.

## Timing
- Reset values: all valid outputs are 0; arready and awready are 0 during reset and 1 in the first cycle after reset deassertion; FSM=IDLE; rd_last=0. Memory contents are not reset.
- Read latency: rvalid rises in the cycle after the AR handshake. rdata is registered and held stable while rvalid=1 and rready=0.
- Write: a data beat is accepted no earlier than the cycle after the AW handshake. bvalid rises in the cycle after the wlast handshake.
- Valid and data outputs never change while valid=1 and ready=0.
- rack or wack arriving in the same cycle as the R or B handshake is ignored; only a pulse in WAIT_* counts.
- The earliest next AR/AW acceptance is the cycle after rack/wack is sampled.
- A read of a line written by the immediately preceding transaction returns the new data (no bypass hazard, because transactions are serialized).
- Reset asserted mid-transaction aborts it: outputs return to reset values immediately (asynchronously), and no partial write beyond beats already handshaked occurs.

## Configuration
- ACE_LINE_MEM_DECERR_EN
  - Defined: any address with bits above the index nonzero (≥ DEPTH×32 bytes) returns DECERR (2'b11) on R or B. The array is not accessed and not written, and the normal handshakes are still completed.
  - Undefined: the upper address bits are ignored and the address wraps modulo DEPTH lines.

## Test plan
- Reset, write line 3 (awaddr=0x60, wstrb=all-ones, wdata=0xA5…A5), then read 0x60 -> bresp=0, bid=awid; rvalid exactly one cycle after the AR handshake, rdata=0xA5…A5, rlast=1, rresp=0.
- Partial write wstrb=0x0000000F, wdata=0x11223344, onto a line previously all-ones, then read -> low 4 bytes=0x11223344, remaining bytes 0xFF.
- arvalid and awvalid asserted together from reset -> read accepted first (awready=0 that cycle); next simultaneous pair -> write accepted first.
- R handshake, then rack held 0 for 5 cycles with a new arvalid pending -> arready stays 0 until the cycle after rack=1.
- awlen=1 with two W beats -> both beats consumed, memory unchanged, bresp=2'b10.
- With ACE_LINE_MEM_DECERR_EN and DEPTH=1024, read 0x8000 -> rresp=2'b11. Without the macro -> returns line 0.
